// File: rtl/fir_mult_pipe_if.sv
// Tap-multiplier bus: clock enable, coefficient load, sample in, product out.
// The master drives samples and coefficients; the slave returns products.
interface fir_mult_pipe_if #(
    parameter int DATA_W = 14,
    parameter int COE_W  = 4,
    parameter int OUT_W  = DATA_W + COE_W
);
    logic              ce;
    logic              coe_load;
    logic [COE_W-1:0]  coe_in;
    logic              in_valid;
    logic [DATA_W-1:0] data;
    logic              out_valid;
    logic [OUT_W-1:0]  fltd;
    logic [COE_W-1:0]  coe_q;

    modport master (
        output ce, coe_load, coe_in, in_valid, data,
        input  out_valid, fltd, coe_q
    );

    modport slave (
        input  ce, coe_load, coe_in, in_valid, data,
        output out_valid, fltd, coe_q
    );
endinterface

// File: rtl/fir_mult_pipe.sv
// Pipelined shift-add FIR tap multiplier: registered partial products feeding
// a registered binary adder tree, with a valid pipeline and a global stall.
module fir_mult_pipe #(
    parameter int DATA_W = 14,
    parameter int COE_W  = 4,
    parameter int SIGNED = 0,
    localparam int OUT_W = DATA_W + COE_W
) (
    input  logic           clk,
    input  logic           rst,
    fir_mult_pipe_if.slave bus
);

    // Terms alive at tree level s, and where level s starts in the flat node array.
    function automatic int cnt(input int s);
        return (COE_W + (1 << s) - 1) >> s;
    endfunction

    function automatic int off(input int s);
        int o;
        o = 0;
        for (int k = 0; k < s; k++) o += cnt(k);
        return o;
    endfunction

    localparam int T     = $clog2(COE_W);
    localparam int NODES = off(T + 1);

    logic [COE_W-1:0] coe_q, coe_d;
    logic [T:0]       vld_q, vld_d;
    logic [OUT_W-1:0] node_q [NODES];
    logic [OUT_W-1:0] node_d [NODES];
    logic [OUT_W-1:0] data_ext;

    always_comb begin
        coe_d = bus.coe_load ? bus.coe_in : coe_q;
    end

    always_comb begin
        if (SIGNED != 0) data_ext = {{COE_W{bus.data[DATA_W-1]}}, bus.data};
        else             data_ext = {{COE_W{1'b0}}, bus.data};
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = bus.in_valid;
        for (int k = 1; k <= T; k++) vld_d[k] = vld_q[k-1];
    end

    // Level 0: one partial product per coefficient bit; the MSB carries
    // negative weight in two's-complement mode.
    for (genvar i = 0; i < COE_W; i++) begin : g_pp
        if (SIGNED != 0 && i == COE_W - 1) begin : g_neg
            assign node_d[i] = coe_q[i] ? -(data_ext << i) : '0;
        end else begin : g_pos
            assign node_d[i] = coe_q[i] ? (data_ext << i) : '0;
        end
    end

    // Levels 1..T: pairwise sums; an unpaired last term passes straight through.
    for (genvar s = 1; s <= T; s++) begin : g_lvl
        for (genvar j = 0; j < cnt(s); j++) begin : g_node
            localparam int A = off(s - 1) + 2 * j;
            if (2 * j + 1 < cnt(s - 1)) begin : g_add
                assign node_d[off(s) + j] = node_q[A] + node_q[A + 1];
            end else begin : g_pass
                assign node_d[off(s) + j] = node_q[A];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coe_q <= '0;
            vld_q <= '0;
            for (int k = 0; k < NODES; k++) node_q[k] <= '0;
        end else if (bus.ce) begin
            coe_q  <= coe_d;
            vld_q  <= vld_d;
            node_q <= node_d;
        end
    end

    assign bus.out_valid = vld_q[T];
    assign bus.fltd      = node_q[NODES-1];
    assign bus.coe_q     = coe_q;

endmodule

// File: tb/tb_fir_mult_pipe.sv
// Scoreboard bench: one unsigned and one two's-complement tap share stimulus;
// expected products are queued at drive time and matched on emergence.
module tb_fir_mult_pipe;

    localparam int DATA_W = 14;
    localparam int COE_W  = 4;
    localparam int OUT_W  = DATA_W + COE_W;
    localparam int L      = 3;

    typedef struct {
        logic [OUT_W-1:0] val;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0, coe_load = 1'b0, in_valid = 1'b0;
    logic [COE_W-1:0]  coe_in = '0;
    logic [DATA_W-1:0] data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int en_edges = 0;
    int cyc = 0;
    logic rst_flag = 1'b0;
    logic [COE_W-1:0] mcoe = '0;

    exp_t             sb [2][$];
    int               last_en [2];
    logic             hold_ov [2];
    logic [OUT_W-1:0] hold_fl [2];

    logic [1:0]       ov;
    logic [OUT_W-1:0] fl [2];
    logic [COE_W-1:0] cq [2];

    fir_mult_pipe_if #(.DATA_W(DATA_W), .COE_W(COE_W)) if0 ();
    fir_mult_pipe_if #(.DATA_W(DATA_W), .COE_W(COE_W)) if1 ();

    fir_mult_pipe #(.DATA_W(DATA_W), .COE_W(COE_W), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .bus(if0.slave));
    fir_mult_pipe #(.DATA_W(DATA_W), .COE_W(COE_W), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .bus(if1.slave));

    assign if0.ce = ce;        assign if1.ce = ce;
    assign if0.coe_load = coe_load; assign if1.coe_load = coe_load;
    assign if0.coe_in = coe_in;  assign if1.coe_in = coe_in;
    assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
    assign if0.data = data;      assign if1.data = data;
    assign ov    = {if1.out_valid, if0.out_valid};
    assign fl[0] = if0.fltd;     assign fl[1] = if1.fltd;
    assign cq[0] = if0.coe_q;    assign cq[1] = if1.coe_q;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] exp_prod(input logic [DATA_W-1:0] d,
                                                  input logic [COE_W-1:0] c, input bit sgn);
        longint p;
        if (sgn) p = longint'($signed(d)) * longint'($signed(c));
        else     p = longint'(d) * longint'(c);
        return p[OUT_W-1:0];
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_flag <= rst;
        if (!rst && ce) en_edges <= en_edges + 1;
        if (cyc > 5000) begin
            $display("FAIL watchdog: got %0d cycles expected <= 5000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    // Output monitor: timing and value of every product, frozen state during stalls.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_flag) begin
                sb[u].delete();
                chk($sformatf("rst_ov%0d", u), 32'(ov[u]), 0);
                chk($sformatf("rst_fltd%0d", u), 32'(fl[u]), 0);
                hold_ov[u] = 1'b0;
                last_en[u] = en_edges;
            end else if (en_edges != last_en[u]) begin
                if (sb[u].size() > 0 && sb[u][0].due == en_edges) begin
                    exp_t e;
                    e = sb[u].pop_front();
                    chk($sformatf("ov%0d", u), 32'(ov[u]), 1);
                    chk($sformatf("fltd%0d", u), 32'(fl[u]), 32'(e.val));
                    hold_ov[u] = 1'b1;
                    hold_fl[u] = e.val;
                end else begin
                    chk($sformatf("idle_ov%0d", u), 32'(ov[u]), 0);
                    hold_ov[u] = 1'b0;
                end
                last_en[u] = en_edges;
            end else if (en_edges > 0) begin
                chk($sformatf("stall_ov%0d", u), 32'(ov[u]), 32'(hold_ov[u]));
                if (hold_ov[u]) chk($sformatf("stall_fltd%0d", u), 32'(fl[u]), 32'(hold_fl[u]));
            end
        end
    end

    task automatic step(input bit c, input bit v, input logic [DATA_W-1:0] d,
                        input bit ld, input logic [COE_W-1:0] cin);
        @(posedge clk); #1;
        ce = c; in_valid = v; data = d; coe_load = ld; coe_in = cin;
        if (c) begin
            if (v)
                for (int u = 0; u < 2; u++)
                    sb[u].push_back('{val: exp_prod(d, mcoe, u[0]), due: en_edges + L});
            if (ld) mcoe = cin;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, data, 0, '0);
    endtask

    task automatic do_rst(input bit c, input bit ld, input logic [COE_W-1:0] cin);
        @(posedge clk); #1;
        rst = 1'b1; ce = c; coe_load = ld; coe_in = cin; in_valid = 1'b0;
        mcoe = '0;
        @(posedge clk); #1;
        rst = 1'b0; ce = 1'b1; coe_load = 1'b0;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("after_rst_coe%0d", u), 32'(cq[u]), 0);
            chk($sformatf("after_rst_fltd%0d", u), 32'(fl[u]), 0);
            chk($sformatf("after_rst_ov%0d", u), 32'(ov[u]), 0);
        end
    endtask

    initial begin
        last_en = '{0, 0};
        hold_ov = '{1'b0, 1'b0};
        hold_fl = '{'0, '0};
        repeat (2) @(posedge clk);
        do_rst(1, 0, '0);

        // Full-scale operands: 3FFF x F
        step(1, 0, '0, 1, 4'hF);
        step(1, 1, 14'h3FFF, 0, '0);
        chk("coe_load_F", 32'(cq[0]), 32'hF);
        idle(5);

        // Streaming 1..4 x 5
        step(1, 0, '0, 1, 4'h5);
        for (int k = 1; k <= 4; k++) step(1, 1, 14'(k), 0, '0);
        idle(5);

        // Signed corner vectors; loads ride alongside samples using the old coefficient
        step(1, 0, '0, 1, 4'hE);
        step(1, 1, 14'h3FFD, 1, 4'h8);
        step(1, 1, 14'h2000, 1, 4'hF);
        step(1, 1, 14'd5, 0, '0);
        chk("coe_load_F2", 32'(cq[1]), 32'hF);
        idle(5);

        // Coefficient switch mid-stream: 20, 20, 30
        step(1, 0, '0, 1, 4'h2);
        step(1, 1, 14'd10, 0, '0);
        step(1, 1, 14'd10, 1, 4'h3);
        step(1, 1, 14'd10, 0, '0);
        idle(5);

        // Stall after acceptance, then stall while the product is on the output
        step(1, 1, 14'd7, 0, '0);
        for (int k = 0; k < 4; k++) step(0, 1, 14'h155, 1, 4'h9);
        step(1, 0, 14'd0, 0, '0);
        step(1, 0, 14'd0, 0, '0);
        for (int k = 0; k < 3; k++) step(0, 1, 14'h2AA, 1, 4'h6);
        chk("stall_coe_hold", 32'(cq[0]), 32'h3);
        idle(4);

        // Reset with two samples in flight
        step(1, 1, 14'd9, 0, '0);
        step(1, 1, 14'd11, 0, '0);
        do_rst(1, 0, '0);
        idle(5);

        // Reset while stalled with a load pending: reset wins
        step(1, 0, '0, 1, 4'h6);
        step(1, 1, 14'd4, 0, '0);
        idle(3);
        do_rst(0, 1, 4'h7);
        idle(5);

        // Random stream with occasional loads and stalls
        for (int k = 0; k < 60; k++) begin
            bit c;
            c = ($urandom_range(0, 4) != 0);
            step(c, 1'($urandom_range(0, 1)), 14'($urandom), 1'($urandom_range(0, 3) == 0),
                 4'($urandom));
        end
        idle(6);

        for (int u = 0; u < 2; u++) chk($sformatf("sb_empty%0d", u), 32'(sb[u].size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
